write_rt_block: RTL

//  Parametrised real-time block writer shared by the Firewire and Ethernet modules.
//  - Buffers NUM_CHAN per-channel DAC quadlets and one power-control quadlet.
//  - Replays them onto the local bus as a timed block write (DAC), then a quadlet write (ctrl).
//  - Generalises the fixed 4-channel writer: configurable channel count, strobe/gap timing
//    and ctrl width; adds a busy flag and optional overrun detection.

---
 rtl/write_rt_block.sv | 211 +++++++++++++++++++++
 1 files changed

// File: rtl/write_rt_block.sv
// write_rt_block
//   Real-time block writer shared by the Firewire and Ethernet paths.
//   It buffers NUM_CHAN DAC quadlets and one power-control quadlet. It then
//   replays them onto the local bus: first as a timed block write (DAC
//   channels), then as a quadlet write (ctrl).
//
//   Optional feature macro: RT_WRITE_OVERRUN_EN
//     - defined:   a write arriving while busy sets the sticky rt_write_err
//                  flag. The write is dropped.
//     - undefined: the write is silently dropped and rt_write_err is tied 0.
//
//   Ports
//     clk, reset       clock, asynchronous active-high reset
//     rt_write_en      store rt_write_data at rt_write_addr (IDLE only)
//     rt_write_addr    0..NUM_CHAN-1 = DAC channel, NUM_CHAN = ctrl/trigger
//     rt_write_data    DAC: bit31 valid, [30:0] value; ctrl: [CTRL_BITS-1:0]
//     rt_busy          high whenever a replay is in progress
//     rt_write_err     sticky overrun flag
//     bw_write_en      local-bus ownership request for the whole replay
//     bw_reg_wen       one-cycle register write strobe
//     bw_block_wen     one-cycle block-complete / quadlet-commit strobe
//     bw_block_wstart  block-write start indication
//     bw_reg_waddr     write address (held between strobes)
//     bw_reg_wdata     write data (held between strobes)
module write_rt_block #(
  parameter int          NUM_CHAN      = 4,
  parameter int          CTRL_BITS     = 20,
  parameter int          WSTART_CYCLES = 4,
  parameter int          GAP_CYCLES    = 3,
  parameter logic [3:0]  DAC_OFF       = 4'h1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        rt_write_en,
  input  logic [3:0]  rt_write_addr,
  input  logic [31:0] rt_write_data,
  output logic        rt_busy,
  output logic        rt_write_err,
  output logic        bw_write_en,
  output logic        bw_reg_wen,
  output logic        bw_block_wen,
  output logic        bw_block_wstart,
  output logic [7:0]  bw_reg_waddr,
  output logic [31:0] bw_reg_wdata
);

  typedef enum logic [2:0] {
    IDLE, WSTART, WRITE, WRITE_GAP, BLK_WEN, WQUAD_GAP, WQUAD
  } state_t;

  state_t               state;
  logic [31:0]          dac [NUM_CHAN];
  logic [CTRL_BITS-1:0] ctrl;
  logic [3:0]           chan;   // channel whose slot is issued next
  logic [4:0]           cnt;    // wait counter (needs to reach GAP_CYCLES+1)
  logic                 any_valid;
  logic [31:0]          cur_dac;

  always_comb begin
    any_valid = 1'b0;
    cur_dac   = '0;
    for (int i = 0; i < NUM_CHAN; i++) begin
      any_valid = any_valid | dac[i][31];
      if (chan == 4'(i)) cur_dac = dac[i];
    end
  end

  assign rt_busy = (state != IDLE);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state           <= IDLE;
      ctrl            <= '0;
      chan            <= '0;
      cnt             <= '0;
      bw_write_en     <= 1'b0;
      bw_reg_wen      <= 1'b0;
      bw_block_wen    <= 1'b0;
      bw_block_wstart <= 1'b0;
      bw_reg_waddr    <= '0;
      bw_reg_wdata    <= '0;
      for (int i = 0; i < NUM_CHAN; i++) dac[i] <= '0;
    end else begin
      case (state)
        IDLE: begin
          bw_write_en     <= 1'b0;
          bw_reg_wen      <= 1'b0;
          bw_block_wen    <= 1'b0;
          bw_block_wstart <= 1'b0;
          chan            <= '0;
          if (rt_write_en) begin
            for (int i = 0; i < NUM_CHAN; i++)
              if (rt_write_addr == 4'(i)) dac[i] <= rt_write_data;
            if (rt_write_addr == 4'(NUM_CHAN)) begin
              ctrl        <= rt_write_data[CTRL_BITS-1:0];
              bw_write_en <= 1'b1;
              if (any_valid) begin
                state           <= WSTART;
                bw_block_wstart <= 1'b1;
                cnt             <= 5'd1;
              end else begin
                // Nothing to block-write: go straight to the ctrl quadlet,
                // which is written even when it is zero.
                state        <= WQUAD;
                bw_reg_wen   <= 1'b1;
                bw_block_wen <= 1'b1;
                bw_reg_waddr <= 8'h00;
                bw_reg_wdata <= 32'(rt_write_data[CTRL_BITS-1:0]);
              end
            end
          end
        end

        WSTART: begin
          if (cnt == 5'(WSTART_CYCLES)) begin
            bw_block_wstart <= 1'b0;
            state           <= WRITE;
            bw_reg_waddr    <= {chan + 4'd1, DAC_OFF};
            bw_reg_wdata    <= {1'b0, cur_dac[30:0]};
            bw_reg_wen      <= cur_dac[31];
            for (int i = 0; i < NUM_CHAN; i++)
              if (chan == 4'(i)) dac[i][31] <= 1'b0;
          end else begin
            cnt <= cnt + 5'd1;
          end
        end

        // Invalid channels still consume a slot so that timing is fixed.
        WRITE: begin
          bw_reg_wen <= 1'b0;
          chan       <= chan + 4'd1;
          cnt        <= 5'd1;
          state      <= WRITE_GAP;
        end

        WRITE_GAP: begin
          if (cnt == 5'(GAP_CYCLES)) begin
            cnt <= 5'd1;
            if (chan == 4'(NUM_CHAN)) begin
              state <= BLK_WEN;
            end else begin
              state        <= WRITE;
              bw_reg_waddr <= {chan + 4'd1, DAC_OFF};
              bw_reg_wdata <= {1'b0, cur_dac[30:0]};
              bw_reg_wen   <= cur_dac[31];
              for (int i = 0; i < NUM_CHAN; i++)
                if (chan == 4'(i)) dac[i][31] <= 1'b0;
            end
          end else begin
            cnt <= cnt + 5'd1;
          end
        end

        // GAP_CYCLES idle cycles, then one cycle with block_wen high.
        BLK_WEN: begin
          if (cnt == 5'(GAP_CYCLES + 1)) begin
            bw_block_wen <= 1'b0;
            if (ctrl == '0) begin
              state       <= IDLE;
              bw_write_en <= 1'b0;
            end else begin
              state <= WQUAD_GAP;
              cnt   <= 5'd1;
            end
          end else begin
            if (cnt == 5'(GAP_CYCLES)) bw_block_wen <= 1'b1;
            cnt <= cnt + 5'd1;
          end
        end

        WQUAD_GAP: begin
          if (cnt == 5'(GAP_CYCLES)) begin
            state        <= WQUAD;
            bw_reg_wen   <= 1'b1;
            bw_block_wen <= 1'b1;
            bw_reg_waddr <= 8'h00;
            bw_reg_wdata <= 32'(ctrl);
          end else begin
            cnt <= cnt + 5'd1;
          end
        end

        WQUAD: begin
          bw_reg_wen   <= 1'b0;
          bw_block_wen <= 1'b0;
          bw_write_en  <= 1'b0;
          ctrl         <= '0;
          state        <= IDLE;
        end

        default: begin
          state           <= IDLE;
          bw_write_en     <= 1'b0;
          bw_reg_wen      <= 1'b0;
          bw_block_wen    <= 1'b0;
          bw_block_wstart <= 1'b0;
        end
      endcase
    end
  end

`ifdef RT_WRITE_OVERRUN_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                      rt_write_err <= 1'b0;
    else if (rt_write_en && rt_busy) rt_write_err <= 1'b1;
  end
`else
  assign rt_write_err = 1'b0;
`endif

endmodule
